// File: rtl/key_conditioner.sv
// Push-button front end: two-flop synchroniser, polarity normalisation and
// an independent debounce FSM per key, with registered level and edge pulses.
module key_conditioner #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_WIDTH       = 20,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                clk,
  input  logic                RST,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                any_pressed
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic [NUM_KEYS-1:0]  RAW_RELEASED = KEY_ACTIVE_LOW ? '1 : '0;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST     = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0]  r_sync1;
  logic [NUM_KEYS-1:0]  r_sync2;
  logic [NUM_KEYS-1:0]  w_p;
  state_t               r_state     [NUM_KEYS];
  state_t               w_state_nxt [NUM_KEYS];
  logic [CNT_WIDTH-1:0] r_cnt       [NUM_KEYS];
  logic [CNT_WIDTH-1:0] w_cnt_nxt   [NUM_KEYS];
  logic [NUM_KEYS-1:0]  w_level_nxt;
  logic [NUM_KEYS-1:0]  w_press_nxt;
  logic [NUM_KEYS-1:0]  w_release_nxt;

  // Synchroniser resets to the released pin value so a key held through
  // reset is seen as a fresh press once reset lifts.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_sync1 <= RAW_RELEASED;
      r_sync2 <= RAW_RELEASED;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_p = KEY_ACTIVE_LOW ? ~r_sync2 : r_sync2;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        r_state[k] <= IDLE;
        r_cnt[k]   <= '0;
      end
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      any_pressed <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      key_level   <= w_level_nxt;
      key_press   <= w_press_nxt;
      key_release <= w_release_nxt;
      any_pressed <= |w_level_nxt;
    end
  end

  always_comb begin
    w_level_nxt   = key_level;
    w_press_nxt   = '0;
    w_release_nxt = '0;
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      w_state_nxt[k] = r_state[k];
      w_cnt_nxt[k]   = r_cnt[k];
      case (r_state[k])
        IDLE: begin
          if (w_p[k]) begin
            w_state_nxt[k] = PRESS_WAIT;
            w_cnt_nxt[k]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!w_p[k]) begin
            w_state_nxt[k] = IDLE;
            w_cnt_nxt[k]   = '0;
          end else if (r_cnt[k] == CNT_LAST) begin
            w_state_nxt[k] = PRESSED;
            w_cnt_nxt[k]   = '0;
            w_level_nxt[k] = 1'b1;
            w_press_nxt[k] = 1'b1;
          end else begin
            w_cnt_nxt[k] = r_cnt[k] + 1'b1;
          end
        end
        PRESSED: begin
          if (!w_p[k]) begin
            w_state_nxt[k] = RELEASE_WAIT;
            w_cnt_nxt[k]   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (w_p[k]) begin
            w_state_nxt[k] = PRESSED;
            w_cnt_nxt[k]   = '0;
          end else if (r_cnt[k] == CNT_LAST) begin
            w_state_nxt[k]   = IDLE;
            w_cnt_nxt[k]     = '0;
            w_level_nxt[k]   = 1'b0;
            w_release_nxt[k] = 1'b1;
          end else begin
            w_cnt_nxt[k] = r_cnt[k] + 1'b1;
          end
        end
        default: begin
          w_state_nxt[k] = IDLE;
          w_cnt_nxt[k]   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: an active-low and an active-high
// instance see mirrored pins and must produce identical outputs.
module tb_key_conditioner;

  localparam int unsigned NK = 4;

  logic          clk;
  logic          RST;
  logic [NK-1:0] key_raw;
  logic [NK-1:0] key_raw_ah;
  logic [NK-1:0] lvl_al, prs_al, rel_al;
  logic [NK-1:0] lvl_ah, prs_ah, rel_ah;
  logic          any_al, any_ah;

  int checks = 0;
  int errors = 0;
  int press_cnt [NK];
  int rel_cnt   [NK];
  int base;

  assign key_raw_ah = ~key_raw;

  key_conditioner #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(8), .CNT_WIDTH(4), .KEY_ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk(clk), .RST(RST), .key_raw(key_raw),
    .key_level(lvl_al), .key_press(prs_al), .key_release(rel_al), .any_pressed(any_al)
  );

  key_conditioner #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(8), .CNT_WIDTH(4), .KEY_ACTIVE_LOW(1'b0)
  ) dut_ah (
    .clk(clk), .RST(RST), .key_raw(key_raw_ah),
    .key_level(lvl_ah), .key_press(prs_ah), .key_release(rel_ah), .any_pressed(any_ah)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int k = 0; k < NK; k++) begin
      press_cnt[k] = 0;
      rel_cnt[k]   = 0;
    end
  end

  // Pulse tallies on the active-low instance, sampled mid-cycle.
  always @(negedge clk) begin
    for (int k = 0; k < NK; k++) begin
      press_cnt[k] = press_cnt[k] + int'(prs_al[k]);
      rel_cnt[k]   = rel_cnt[k] + int'(rel_al[k]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [NK-1:0] lvl,
                         input logic [NK-1:0] prs, input logic [NK-1:0] rel);
    chk({tag, "/lvl_al"}, 32'(lvl_al), 32'(lvl));
    chk({tag, "/prs_al"}, 32'(prs_al), 32'(prs));
    chk({tag, "/rel_al"}, 32'(rel_al), 32'(rel));
    chk({tag, "/any_al"}, 32'(any_al), 32'(|lvl));
    chk({tag, "/lvl_ah"}, 32'(lvl_ah), 32'(lvl));
    chk({tag, "/prs_ah"}, 32'(prs_ah), 32'(prs));
    chk({tag, "/rel_ah"}, 32'(rel_ah), 32'(rel));
    chk({tag, "/any_ah"}, 32'(any_ah), 32'(|lvl));
  endtask

  initial begin
    RST     = 1'b0;
    key_raw = '1;
    #23;
    chk_all("reset", 4'b0000, 4'b0000, 4'b0000);
    cyc(1);
    RST = 1'b1;
    cyc(3);
    chk_all("idle", 4'b0000, 4'b0000, 4'b0000);

    // Clean press on key 0: level rises at edge E+10 after the drive.
    key_raw[0] = 1'b0;
    cyc(10);
    chk_all("press0_pre", 4'b0000, 4'b0000, 4'b0000);
    cyc(1);
    chk_all("press0_edge", 4'b0001, 4'b0001, 4'b0000);
    cyc(1);
    chk_all("press0_after", 4'b0001, 4'b0000, 4'b0000);
    cyc(18);
    chk_all("press0_hold", 4'b0001, 4'b0000, 4'b0000);
    chk("press0_count", 32'(press_cnt[0]), 32'd1);

    // Release bounce on key 0: 4 cycles released, 2 pressed, then released.
    base = rel_cnt[0];
    key_raw[0] = 1'b1;
    cyc(4);
    chk_all("bounce_mid1", 4'b0001, 4'b0000, 4'b0000);
    key_raw[0] = 1'b0;
    cyc(2);
    key_raw[0] = 1'b1;
    cyc(10);
    chk_all("release0_pre", 4'b0001, 4'b0000, 4'b0000);
    cyc(1);
    chk_all("release0_edge", 4'b0000, 4'b0000, 4'b0001);
    cyc(1);
    chk_all("release0_after", 4'b0000, 4'b0000, 4'b0000);
    cyc(10);
    chk("release0_count", 32'(rel_cnt[0] - base), 32'd1);

    // Press glitch on key 0: 5 cycles pressed, never accepted.
    base = press_cnt[0];
    key_raw[0] = 1'b0;
    cyc(5);
    key_raw[0] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      cyc(1);
      chk_all("glitch", 4'b0000, 4'b0000, 4'b0000);
    end
    chk("glitch_count", 32'(press_cnt[0] - base), 32'd0);

    // Independence: keys 1 and 3 together, key 3 released afterwards.
    key_raw[1] = 1'b0;
    key_raw[3] = 1'b0;
    cyc(10);
    chk_all("ind_pre", 4'b0000, 4'b0000, 4'b0000);
    cyc(1);
    chk_all("ind_press", 4'b1010, 4'b1010, 4'b0000);
    cyc(3);
    key_raw[3] = 1'b1;
    cyc(10);
    chk_all("ind_rel_pre", 4'b1010, 4'b0000, 4'b0000);
    cyc(1);
    chk_all("ind_rel_edge", 4'b0010, 4'b0000, 4'b1000);
    cyc(1);
    chk_all("ind_rel_after", 4'b0010, 4'b0000, 4'b0000);

    // Reset mid-window on key 2 (cnt==5), keys 1 and 2 held throughout.
    key_raw[2] = 1'b0;
    cyc(8);
    chk_all("rst_win_pre", 4'b0010, 4'b0000, 4'b0000);
    #2;
    RST = 1'b0;
    #1;
    chk_all("rst_async", 4'b0000, 4'b0000, 4'b0000);
    cyc(2);
    chk_all("rst_held", 4'b0000, 4'b0000, 4'b0000);
    RST = 1'b1;
    cyc(10);
    chk_all("rst_resume_pre", 4'b0000, 4'b0000, 4'b0000);
    cyc(1);
    chk_all("rst_resume_edge", 4'b0110, 4'b0110, 4'b0000);
    cyc(1);
    chk_all("rst_resume_after", 4'b0110, 4'b0000, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Front-end conditioner for the board push buttons. Sits directly upstream of the per-key auto-repeat stage.
- Synchronises raw, asynchronous, bouncing button inputs and debounces each key independently.
- Drives a clean level per key (this level is the auto-repeat stage's key_push input) plus one-cycle press and release pulses for logic that needs edge events.

Parameters:
- NUM_KEYS, 4, number of independent buttons (left, right, rotate, drop).
- DEBOUNCE_CYCLES, 500000, cycles the synchronised input must be stable before a change is accepted (10 ms at 50 MHz). Legal range 2 to 2^CNT_WIDTH.
- CNT_WIDTH, 20, width of each debounce counter.
- KEY_ACTIVE_LOW, 1, 1 means a raw key reads 0 when pressed; 0 means it reads 1 when pressed.

Ports:
- clk  input  1  system clock.
- RST  input  1  asynchronous, active-low reset.
- key_raw  input  NUM_KEYS  raw button pins, asynchronous to clk.
- key_level  output  NUM_KEYS  debounced level, 1 = pressed; feeds key_push of the repeat stage.
- key_press  output  NUM_KEYS  one-cycle pulse on each accepted press.
- key_release  output  NUM_KEYS  one-cycle pulse on each accepted release.
- any_pressed  output  1  OR of key_level.

Behaviour:
- Reset (RST=0, asynchronous):
  - All outputs 0.
  - All FSMs in IDLE; all counters 0.
  - Both synchroniser flops load the "released" raw value (1 if KEY_ACTIVE_LOW=1, else 0).
- Synchroniser and polarity:
  - Per key, two-flop synchroniser on key_raw.
  - Polarity-normalised to p (1 = pressed) after the second flop.
  - No logic reads the first flop.
- Per-key FSM, each key fully independent, one counter cnt per key:
  - IDLE (level 0): if p=1, go to PRESS_WAIT with cnt=0.
  - PRESS_WAIT (level 0):
    - If p=0, return to IDLE with cnt=0 (glitch rejected, no pulse).
    - Else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED: key_level<=1, key_press<=1.
    - Else cnt<=cnt+1.
  - PRESSED (level 1): if p=0, go to RELEASE_WAIT with cnt=0.
  - RELEASE_WAIT (level 1):
    - If p=1, return to PRESSED with cnt=0 (bounce rejected, no pulse).
    - Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE: key_level<=0, key_release<=1.
    - Else cnt<=cnt+1.
- Outputs:
  - All outputs are registered.
  - key_press and key_release are high for exactly one cycle, then cleared on the next edge.
  - key_press[i] and key_release[i] are never high together.
- Latency:
  - Take edge E as the first clock edge whose first synchroniser flop samples the new stable raw value.
  - key_level changes, and the matching pulse asserts, at edge E+DEBOUNCE_CYCLES+2.
  - The window is measured with counting edges from PRESS_WAIT/RELEASE_WAIT entry through cnt==DEBOUNCE_CYCLES-1.
  - Fixed latency; no jitter beyond synchroniser sampling.
- Bounce rejection: any p toggle inside a wait window restarts that key's window. The counter never wraps because it is bounded by DEBOUNCE_CYCLES-1.
- Key held through reset release: the key is treated as a new press and is accepted after the full latency.
- Reset mid-window: aborts the window with no pulse. The FSM resumes from IDLE.
- Simultaneous events: several keys may change in the same cycle, and any combination of key_press and key_release bits may be high in one cycle.
- any_pressed is the registered OR of the next key_level values, so it is aligned with key_level.

Test Plan (DEBOUNCE_CYCLES=8, KEY_ACTIVE_LOW=1):
- Clean press: drive key_raw[0]=0 held for 30 cycles.
  - key_level[0] rises exactly 10 edges after the first sampling edge.
  - key_press[0] is high for 1 cycle only; any_pressed=1 in the same cycle.
- Press glitch: key_raw[0]=0 for 5 cycles, then 1.
  - key_level, key_press and key_release stay 0 throughout.
- Release bounce: after a clean press, drive key_raw[0] to 1 for 4 cycles, back to 0 for 2 cycles, then 1 steady.
  - key_level[0] holds 1 through the bounce and falls 10 edges after the final 0→1 is sampled.
  - Exactly one key_release[0] pulse.
- Independence: press key 1 and key 3 on the same edge, release key 3 three cycles later.
  - key_press[1] and key_press[3] assert in the same cycle.
  - key_release[3] fires while key_level[1] stays 1.
- Reset mid-window: press key 2 and assert RST=0 at cnt=5, keeping key 2 pressed.
  - All outputs are 0 immediately (asynchronous).
  - After RST=1, key_press[2] fires DEBOUNCE_CYCLES+2 edges after the first post-reset sampling edge.
- Polarity: with KEY_ACTIVE_LOW=0, repeat the clean-press scenario with inverted stimulus → identical output timing.
